eval_exp_dma_sched: RTL and testbench

EVAL_EXP_DMA_SCHED -- requirements
Module: eval_exp_dma_sched

---
 rtl/eval_exp_dma_sched.sv | 161 ++++++++++++++++
 tb/tb_eval_exp_dma_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eval_exp_dma_sched.sv
// Splits a copy job into read/write DMA command bursts that never cross a 4 KB
// page on either side, limiting how many write bursts are in flight at once.
module eval_exp_dma_sched #(
  parameter int unsigned ADDR_BITS   = 40,
  parameter int unsigned LEN_BITS    = 32,
  parameter int unsigned MAX_BURST   = 64,
  parameter int unsigned ISSUE_DEPTH = 4
) (
  input  logic                 reset,
  input  logic                 clk,
  input  logic                 s_start,
  input  logic [ADDR_BITS-1:0] s_src_addr,
  input  logic [ADDR_BITS-1:0] s_dst_addr,
  input  logic [LEN_BITS-1:0]  s_len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] m_rd_cmd_addr,
  output logic [7:0]           m_rd_cmd_len,
  output logic                 m_rd_cmd_valid,
  input  logic                 m_rd_cmd_ready,
  output logic [ADDR_BITS-1:0] m_wr_cmd_addr,
  output logic [7:0]           m_wr_cmd_len,
  output logic                 m_wr_cmd_valid,
  input  logic                 m_wr_cmd_ready,
  input  logic                 s_wr_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_t;

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_src;
  logic [ADDR_BITS-1:0] r_dst;
  logic [LEN_BITS-1:0]  r_rem;
  logic [8:0]           r_beats;
  logic                 r_pend;
  logic [3:0]           r_out;

  // Beats left before the 4 KB page ends are 256 minus the 16-byte page offset.
  function automatic logic [8:0] f_beats(input logic [7:0] src_pg,
                                         input logic [7:0] dst_pg,
                                         input logic [LEN_BITS-1:0] rem);
    logic [8:0] b;
    logic [8:0] src_room;
    logic [8:0] dst_room;
    src_room = 9'd256 - {1'b0, src_pg};
    dst_room = 9'd256 - {1'b0, dst_pg};
    if (rem > LEN_BITS'(MAX_BURST)) b = 9'(MAX_BURST);
    else                            b = rem[8:0];
    if (src_room < b) b = src_room;
    if (dst_room < b) b = dst_room;
    return b;
  endfunction

  logic                 w_idle;
  logic [ADDR_BITS-1:0] w_p_src;
  logic [ADDR_BITS-1:0] w_p_dst;
  logic [LEN_BITS-1:0]  w_p_rem;
  logic [8:0]           w_p_beats;
  logic                 w_rd_ok;
  logic                 w_wr_ok;
  logic                 w_accept;
  logic                 w_dec;
  logic [3:0]           w_out_next;
  logic                 w_slot;
  logic [ADDR_BITS-1:0] w_step;
  logic [LEN_BITS-1:0]  w_rem_after;

  // In IDLE the first burst is sized straight from the start inputs so that
  // commands are valid the cycle after s_start.
  assign w_idle      = (r_state == S_IDLE);
  assign w_p_src     = w_idle ? (s_src_addr & ~ADDR_BITS'(15)) : r_src;
  assign w_p_dst     = w_idle ? (s_dst_addr & ~ADDR_BITS'(15)) : r_dst;
  assign w_p_rem     = w_idle ? s_len : r_rem;
  assign w_p_beats   = f_beats(w_p_src[11:4], w_p_dst[11:4], w_p_rem);

  assign w_rd_ok     = ~m_rd_cmd_valid | m_rd_cmd_ready;
  assign w_wr_ok     = ~m_wr_cmd_valid | m_wr_cmd_ready;
  assign w_accept    = (r_state == S_ISSUE) & r_pend & w_rd_ok & w_wr_ok;
  assign w_dec       = s_wr_done & (r_out != 4'd0);
  assign w_out_next  = r_out + 4'(w_accept) - 4'(w_dec);
  assign w_slot      = (r_out - 4'(w_dec)) < 4'(ISSUE_DEPTH);
  assign w_step      = ADDR_BITS'({r_beats, 4'b0000});
  assign w_rem_after = r_rem - LEN_BITS'(r_beats);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_src          <= '0;
      r_dst          <= '0;
      r_rem          <= '0;
      r_beats        <= '0;
      r_pend         <= 1'b0;
      r_out          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      m_rd_cmd_addr  <= '0;
      m_rd_cmd_len   <= '0;
      m_rd_cmd_valid <= 1'b0;
      m_wr_cmd_addr  <= '0;
      m_wr_cmd_len   <= '0;
      m_wr_cmd_valid <= 1'b0;
    end else begin
      if (m_rd_cmd_valid && m_rd_cmd_ready) m_rd_cmd_valid <= 1'b0;
      if (m_wr_cmd_valid && m_wr_cmd_ready) m_wr_cmd_valid <= 1'b0;
      r_out <= w_out_next;
      done  <= 1'b0;

      // A burst is presented from IDLE on start, or in ISSUE once the previous
      // one is fully accepted and a slot is free (counting this cycle's s_wr_done).
      if ((w_idle && s_start && s_len != '0) ||
          (r_state == S_ISSUE && !r_pend && r_rem != '0 && w_slot)) begin
        m_rd_cmd_addr  <= w_p_src;
        m_wr_cmd_addr  <= w_p_dst;
        m_rd_cmd_len   <= 8'(w_p_beats - 9'd1);
        m_wr_cmd_len   <= 8'(w_p_beats - 9'd1);
        m_rd_cmd_valid <= 1'b1;
        m_wr_cmd_valid <= 1'b1;
        r_beats        <= w_p_beats;
        r_pend         <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (s_start) begin
            r_src <= w_p_src;
            r_dst <= w_p_dst;
            r_rem <= s_len;
            busy  <= 1'b1;
            if (s_len == '0) begin
              r_state <= S_FINISH;
              done    <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_src  <= r_src + w_step;
            r_dst  <= r_dst + w_step;
            r_rem  <= w_rem_after;
            r_pend <= 1'b0;
            if (w_rem_after == '0) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_out_next == 4'd0) begin
            r_state <= S_FINISH;
            done    <= 1'b1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eval_exp_dma_sched.sv
// Directed bench for eval_exp_dma_sched: zero-length, splitting, 4 KB crossing,
// flow control, backpressure, address wrap and reset mid-job.
module tb_eval_exp_dma_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_start = 1'b0;
  logic [39:0] s_src_addr = '0;
  logic [39:0] s_dst_addr = '0;
  logic [31:0] s_len = '0;
  logic        busy, done;
  logic [39:0] m_rd_cmd_addr, m_wr_cmd_addr;
  logic [7:0]  m_rd_cmd_len, m_wr_cmd_len;
  logic        m_rd_cmd_valid, m_wr_cmd_valid;
  logic        m_rd_cmd_ready = 1'b1;
  logic        m_wr_cmd_ready = 1'b1;
  logic        s_wr_done = 1'b0;

  eval_exp_dma_sched #(
    .ADDR_BITS(40), .LEN_BITS(32), .MAX_BURST(64), .ISSUE_DEPTH(2)
  ) dut (
    .reset(reset), .clk(clk), .s_start(s_start),
    .s_src_addr(s_src_addr), .s_dst_addr(s_dst_addr), .s_len(s_len),
    .busy(busy), .done(done),
    .m_rd_cmd_addr(m_rd_cmd_addr), .m_rd_cmd_len(m_rd_cmd_len),
    .m_rd_cmd_valid(m_rd_cmd_valid), .m_rd_cmd_ready(m_rd_cmd_ready),
    .m_wr_cmd_addr(m_wr_cmd_addr), .m_wr_cmd_len(m_wr_cmd_len),
    .m_wr_cmd_valid(m_wr_cmd_valid), .m_wr_cmd_ready(m_wr_cmd_ready),
    .s_wr_done(s_wr_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int vld_cycles = 0;
  int dc0, vld0, good;
  logic [63:0] rd_a[$], rd_l[$], wr_a[$], wr_l[$];

  always @(posedge clk) begin
    if (!reset) begin
      if (m_rd_cmd_valid && m_rd_cmd_ready) begin
        rd_a.push_back(64'(m_rd_cmd_addr));
        rd_l.push_back(64'(m_rd_cmd_len));
      end
      if (m_wr_cmd_valid && m_wr_cmd_ready) begin
        wr_a.push_back(64'(m_wr_cmd_addr));
        wr_l.push_back(64'(m_wr_cmd_len));
      end
      if (done) done_cnt++;
      if (m_rd_cmd_valid || m_wr_cmd_valid) vld_cycles++;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    rd_a.delete(); rd_l.delete(); wr_a.delete(); wr_l.delete();
  endtask

  task automatic start_job(input logic [39:0] src, input logic [39:0] dst, input logic [31:0] len);
    s_src_addr = src; s_dst_addr = dst; s_len = len; s_start = 1'b1;
    step(1);
    s_start = 1'b0;
  endtask

  task automatic pulse_wr_done();
    s_wr_done = 1'b1;
    step(1);
    s_wr_done = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int i;
    i = 0;
    while (!done && i < max) begin
      step(1);
      i++;
    end
    check_eq({tag, " done"}, 64'(done), 64'd1);
    step(1);
    check_eq({tag, " done width"}, 64'(done), 64'd0);
    check_eq({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    check_eq("rst busy", 64'(busy), 0);
    check_eq("rst done", 64'(done), 0);
    check_eq("rst rd_valid", 64'(m_rd_cmd_valid), 0);
    check_eq("rst wr_valid", 64'(m_wr_cmd_valid), 0);
    check_eq("rst rd_addr", 64'(m_rd_cmd_addr), 0);
    check_eq("rst wr_len", 64'(m_wr_cmd_len), 0);
    reset = 1'b0;
    step(1);

    // zero-length job
    vld0 = vld_cycles; dc0 = done_cnt;
    start_job(40'h100, 40'h200, 32'd0);
    check_eq("zl done", 64'(done), 1);
    check_eq("zl busy", 64'(busy), 1);
    check_eq("zl rd_valid", 64'(m_rd_cmd_valid), 0);
    step(1);
    check_eq("zl done low", 64'(done), 0);
    check_eq("zl busy low", 64'(busy), 0);
    step(1);
    check_eq("zl done count", 64'(done_cnt - dc0), 1);
    check_eq("zl no valid", 64'(vld_cycles - vld0), 0);

    // basic split
    clear_q();
    start_job(40'h1000, 40'h2000, 32'd100);
    check_eq("split first rd_valid", 64'(m_rd_cmd_valid), 1);
    check_eq("split first wr_valid", 64'(m_wr_cmd_valid), 1);
    step(8);
    check_eq("split rd count", 64'(rd_a.size()), 2);
    check_eq("split wr count", 64'(wr_a.size()), 2);
    check_eq("split rd0 addr", rd_a[0], 64'h1000);
    check_eq("split rd0 len", rd_l[0], 63);
    check_eq("split rd1 addr", rd_a[1], 64'h1400);
    check_eq("split rd1 len", rd_l[1], 35);
    check_eq("split wr0 addr", wr_a[0], 64'h2000);
    check_eq("split wr0 len", wr_l[0], 63);
    check_eq("split wr1 addr", wr_a[1], 64'h2400);
    check_eq("split wr1 len", wr_l[1], 35);
    dc0 = done_cnt;
    pulse_wr_done();
    step(3);
    check_eq("split no early done", 64'(done_cnt - dc0), 0);
    check_eq("split still busy", 64'(busy), 1);
    pulse_wr_done();
    wait_done("split", 5);

    // 4 KB crossing on the source side
    clear_q();
    start_job(40'h0F80, 40'h5000, 32'd16);
    step(6);
    check_eq("4k rd count", 64'(rd_a.size()), 2);
    check_eq("4k rd0 addr", rd_a[0], 64'h0F80);
    check_eq("4k rd0 len", rd_l[0], 7);
    check_eq("4k wr0 addr", wr_a[0], 64'h5000);
    check_eq("4k rd1 addr", rd_a[1], 64'h1000);
    check_eq("4k rd1 len", rd_l[1], 7);
    check_eq("4k wr1 addr", wr_a[1], 64'h5080);
    check_eq("4k wr1 len", wr_l[1], 7);
    pulse_wr_done();
    pulse_wr_done();
    wait_done("4k", 5);

    // flow control with two outstanding bursts
    clear_q();
    start_job(40'h0, 40'h10000, 32'd256);
    step(10);
    check_eq("fc stall count", 64'(rd_a.size()), 2);
    check_eq("fc stall rd_valid", 64'(m_rd_cmd_valid), 0);
    s_wr_done = 1'b1;
    step(1);
    s_wr_done = 1'b0;
    check_eq("fc slot rd_valid", 64'(m_rd_cmd_valid), 1);
    check_eq("fc slot wr_valid", 64'(m_wr_cmd_valid), 1);
    check_eq("fc b2 rd addr", 64'(m_rd_cmd_addr), 64'h800);
    check_eq("fc b2 wr addr", 64'(m_wr_cmd_addr), 64'h10800);
    check_eq("fc b2 len", 64'(m_rd_cmd_len), 63);
    step(5);
    check_eq("fc third count", 64'(rd_a.size()), 3);
    check_eq("fc restall rd_valid", 64'(m_rd_cmd_valid), 0);
    pulse_wr_done();
    step(5);
    check_eq("fc fourth count", 64'(rd_a.size()), 4);
    check_eq("fc b3 rd addr", rd_a[3], 64'hC00);
    dc0 = done_cnt;
    pulse_wr_done();
    step(4);
    check_eq("fc no done after 3", 64'(done_cnt - dc0), 0);
    check_eq("fc busy after 3", 64'(busy), 1);
    pulse_wr_done();
    wait_done("fc", 5);

    // write backpressure plus a start pulse while busy
    clear_q();
    m_wr_cmd_ready = 1'b0;
    start_job(40'h3000, 40'h4000, 32'd100);
    good = 0;
    for (int k = 0; k < 10; k++) begin
      if (m_wr_cmd_valid && m_wr_cmd_addr == 40'h4000 && m_wr_cmd_len == 8'd63 &&
          (k == 0 || !m_rd_cmd_valid)) good++;
      s_start = (k == 2);
      s_src_addr = 40'h9000; s_dst_addr = 40'hA000; s_len = 32'd5;
      step(1);
    end
    s_start = 1'b0;
    check_eq("bp stable cycles", 64'(good), 10);
    check_eq("bp rd once", 64'(rd_a.size()), 1);
    check_eq("bp wr none", 64'(wr_a.size()), 0);
    check_eq("bp busy", 64'(busy), 1);
    m_wr_cmd_ready = 1'b1;
    step(4);
    check_eq("bp rd count", 64'(rd_a.size()), 2);
    check_eq("bp wr count", 64'(wr_a.size()), 2);
    check_eq("bp rd1 addr", rd_a[1], 64'h3400);
    check_eq("bp rd1 len", rd_l[1], 35);
    check_eq("bp wr1 addr", wr_a[1], 64'h4400);
    pulse_wr_done();
    pulse_wr_done();
    wait_done("bp", 5);

    // source address wraps past the top of the address space
    clear_q();
    start_job(40'hFF_FFFF_FC00, 40'h0, 32'd128);
    step(6);
    check_eq("wrap rd0 addr", rd_a[0], 64'hFF_FFFF_FC00);
    check_eq("wrap rd0 len", rd_l[0], 63);
    check_eq("wrap rd1 addr", rd_a[1], 64'h0);
    check_eq("wrap wr1 addr", wr_a[1], 64'h400);
    pulse_wr_done();
    pulse_wr_done();
    wait_done("wrap", 5);

    // reset during DRAIN, then start right after reset
    clear_q();
    start_job(40'h6000, 40'h7000, 32'd20);
    step(4);
    check_eq("rmj busy", 64'(busy), 1);
    check_eq("rmj rd count", 64'(rd_a.size()), 1);
    dc0 = done_cnt;
    reset = 1'b1;
    step(1);
    check_eq("rmj busy", 64'(busy), 0);
    check_eq("rmj done", 64'(done), 0);
    check_eq("rmj rd_valid", 64'(m_rd_cmd_valid), 0);
    check_eq("rmj wr_valid", 64'(m_wr_cmd_valid), 0);
    check_eq("rmj rd_addr", 64'(m_rd_cmd_addr), 0);
    check_eq("rmj wr_addr", 64'(m_wr_cmd_addr), 0);
    check_eq("rmj rd_len", 64'(m_rd_cmd_len), 0);
    reset = 1'b0;
    start_job(40'h8000, 40'h9000, 32'd1);
    check_eq("post-rst rd_valid", 64'(m_rd_cmd_valid), 1);
    check_eq("post-rst rd_addr", 64'(m_rd_cmd_addr), 64'h8000);
    check_eq("post-rst rd_len", 64'(m_rd_cmd_len), 0);
    check_eq("rmj no done", 64'(done_cnt - dc0), 0);
    step(2);
    pulse_wr_done();
    wait_done("post-rst", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
